ddr2_refresh_ctrl: RTL and testbench
====================================

# ddr2_refresh_ctrl

Auto-refresh scheduler and command generator for the DDR2 controller. It sits between the initialisation sequencer and the command mux that drives the `ddr2_*` pins of `ddr2_top`. After `init_done`, it counts the refresh interval and requests the command bus from the arbiter. Once granted, it drives PRECHARGE ALL and then REFRESH onto the DRAM command bus, honouring tRP and tRFC.

## Interface
- `TREFI`, 1560: refresh interval in `ck` cycles (7.8 us at 200 MHz).
- `TRP`, 3: PRECHARGE-to-REFRESH spacing, in cycles.
- `TRFC`, 26: REFRESH-to-next-command spacing, in cycles.
- `ck`  in  1  controller clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `init_done`  in  1  level; high once the DRAM initialisation sequence has completed.
- `ref_req`  out  1  request for the command bus.
- `ref_grant`  in  1  arbiter grant; sampled only while `ref_req` is high.
- `ref_busy`  out  1  high while this block owns the command bus.
- `ref_done`  out  1  one-cycle pulse marking the end of a sequence.
- `ref_miss`  out  1  sticky refresh-overflow flag; cleared only by reset.
- `cs_n`, `ras_n`, `cas_n`, `we_n`  out  1 each  DRAM command signals.
- `ba`  out  `BA_BITS`  bank address.
- `addr`  out  `ADDR_BITS`  address bus.

## Operation
- **Commands:**
  - NOP = cs_n 0, ras_n 1, cas_n 1, we_n 1.
  - PRE-ALL = cs_n 0, ras_n 0, cas_n 1, we_n 0, with `addr[10]` = 1.
  - REF = cs_n 0, ras_n 0, cas_n 0, we_n 1.
  - `ba` and all other `addr` bits are 0.
- **Interval timer:**
  - Held at `TREFI-1` while `init_done` is low.
  - Decrements every cycle while `init_done` is high.
  - On reaching 0 it reloads and adds one refresh to the pending count.
- **States and transitions:**
  - IDLE → REQ when the pending count is nonzero.
  - REQ → PRE when `ref_grant` is sampled high.
  - PRE → TRP_WAIT after 1 cycle.
  - TRP_WAIT → REF after `TRP-1` cycles.
  - REF → TRFC_WAIT after 1 cycle.
  - TRFC_WAIT → DONE after `TRFC-1` cycles.
  - DONE → IDLE after 1 cycle.
- **Outputs per state:**
  - `ref_req` = (state == REQ).
  - `ref_busy` is high in PRE through TRFC_WAIT.
  - `ref_done` is high in DONE only.
  - The command bus carries NOP in every state except PRE and REF.
- **Pending count:**
  - Decrements in REF.
  - A timer expiry in the same cycle as REF leaves the count unchanged.
- **`init_done` falling:**
  - In IDLE or REQ, the block returns to IDLE and clears the pending count in the next cycle.
  - A sequence that has already started (PRE onward) completes first.
- **Reset:** async assertion forces IDLE, pending count 0, and timer `TREFI-1` immediately.

## Timing
- **Reset values:**
  - `ref_req`, `ref_busy`, `ref_done` and `ref_miss` = 0.
  - Command outputs = NOP (cs_n 0, ras_n 1, cas_n 1, we_n 1).
  - `ba` = 0, `addr` = 0.
- All outputs are registered.
- **Request timing:** `ref_req` rises on the cycle after the expiry edge. It stays high until the cycle after `ref_grant` is sampled high, and falls in the same cycle that `ref_busy` rises.
- **Grant to PRE:** PRE-ALL appears on the bus 1 cycle after the grant edge.
- **PRE to REF:** REF appears exactly `TRP` cycles after PRE-ALL.
- **REF to done:** `ref_done` pulses `TRFC` cycles after REF. `ref_busy` falls in the same cycle, so the arbiter may issue a command on the following edge.
- **`ref_grant` outside REQ:** ignored.

## Configuration
- **`DDR2_REF_POSTPONE_EN` defined:**
  - The pending count is 4 bits, range 0..8.
  - After TRFC_WAIT, the block returns to REF (no new PRE-ALL, `ref_busy` held) while the pending count is nonzero, so postponed refreshes are issued back-to-back.
  - `ref_miss` sets on an expiry when the count is already 8; the count saturates at 8.
- **Undefined:**
  - The pending count is 1 bit, and there is exactly one REF per grant.
  - `ref_miss` sets on an expiry while a refresh is already pending.

## Structure
- Command encodings (`CMD_NOP`, `CMD_PRE`, `CMD_REF`), `BA_BITS`, `ADDR_BITS` and the default timing values belong in the shared `rtl/define.v`.
- The interval counter and pending-count logic form one sub-module, `ddr2_ref_timer` (outputs: `pending_nz`, `miss`; input: `dec`).
- The FSM and command drive stay in `ddr2_refresh_ctrl`.

## Test plan
- **Nominal refresh:** `TREFI`=20, `TRP`=3, `TRFC`=26; raise `init_done`, grant 2 cycles after `ref_req` → PRE-ALL (`addr[10]`=1) 1 cycle after the grant edge, REF 3 cycles later, `ref_done` pulse 26 cycles after REF, NOP on all other cycles.
- **Held request:** hold `ref_grant` low for 50 cycles → `ref_req` stays high, bus stays NOP, `ref_busy` stays 0.
- **Missed refresh, macro undefined:** `TREFI`=20, no grant for 45 cycles → `ref_miss`=1 after the second expiry; a single REF after the grant.
- **Postponed refreshes, macro defined:** same stimulus → one PRE-ALL, then 2 REFs spaced 26 cycles apart, `ref_busy` continuous, `ref_miss` remains 0.
- **Reset and `init_done` drop:**
  - Assert `rst_n` low during TRFC_WAIT → outputs immediately at reset values; after release, the first `ref_req` comes `TREFI` cycles after `init_done` is high.
  - Drop `init_done` while in REQ → `ref_req` low the next cycle and no PRE-ALL issued.

Source files
------------

// File: rtl/ddr2_refresh_ctrl_pkg.sv
// Shared encodings, widths and timing defaults for the DDR2 auto-refresh block.
// DDR2_REF_POSTPONE_EN selects the deep (0..8) pending-refresh counter.
package ddr2_refresh_ctrl_pkg;

  localparam int BA_BITS   = 3;
  localparam int ADDR_BITS = 14;

  localparam int DEF_TREFI = 1560;
  localparam int DEF_TRP   = 3;
  localparam int DEF_TRFC  = 26;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } cmd_t;

  localparam cmd_t CMD_NOP = 4'b0111;
  localparam cmd_t CMD_PRE = 4'b0010;
  localparam cmd_t CMD_REF = 4'b0001;

`ifdef DDR2_REF_POSTPONE_EN
  localparam int PEND_W   = 4;
  localparam int PEND_MAX = 8;
`else
  localparam int PEND_W   = 1;
  localparam int PEND_MAX = 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_PRE,
    S_TRP_WAIT,
    S_REF,
    S_TRFC_WAIT,
    S_DONE
  } state_t;

  // Command bus is owned from PRE-ALL until the last tRFC wait ends.
  function automatic logic busy_state(input state_t s);
    return (s == S_PRE) || (s == S_TRP_WAIT) || (s == S_REF) || (s == S_TRFC_WAIT);
  endfunction

endpackage

// File: rtl/ddr2_ref_timer.sv
// Refresh interval counter and pending-refresh bookkeeping.
// Counter depth depends on DDR2_REF_POSTPONE_EN (via PEND_W/PEND_MAX).
module ddr2_ref_timer
  import ddr2_refresh_ctrl_pkg::*;
#(
  parameter int TREFI = DEF_TREFI
) (
  input  logic ck,
  input  logic rst_n,
  input  logic init_done,
  input  logic clr,
  input  logic dec,
  output logic pending_nz,
  output logic miss
);

  localparam int              CW     = $clog2(TREFI + 1);
  localparam logic [CW-1:0]     RELOAD = CW'(TREFI - 1);
  localparam logic [PEND_W-1:0] PMAX   = PEND_W'(PEND_MAX);

  logic [CW-1:0]     cnt;
  logic [PEND_W-1:0] pend;
  logic              expire;

  assign expire     = init_done && (cnt == '0);
  // Include the expiring interval so the FSM can request on the expiry edge itself.
  assign pending_nz = (pend != '0) || expire;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)                  cnt <= RELOAD;
    else if (!init_done || expire) cnt <= RELOAD;
    else                         cnt <= cnt - 1'b1;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      miss <= 1'b0;
    end else if (clr) begin
      pend <= '0;
    end else if (expire && !dec) begin
      if (pend == PMAX) miss <= 1'b1;
      else              pend <= pend + 1'b1;
    end else if (dec && !expire && (pend != '0)) begin
      pend <= pend - 1'b1;
    end
  end

endmodule

// File: rtl/ddr2_refresh_ctrl.sv
// DDR2 auto-refresh FSM: requests the bus, issues PRE-ALL then REF, honours tRP/tRFC.
// With DDR2_REF_POSTPONE_EN, postponed refreshes are issued back-to-back in one grant.
module ddr2_refresh_ctrl
  import ddr2_refresh_ctrl_pkg::*;
#(
  parameter int TREFI = DEF_TREFI,
  parameter int TRP   = DEF_TRP,
  parameter int TRFC  = DEF_TRFC
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 init_done,
  output logic                 ref_req,
  input  logic                 ref_grant,
  output logic                 ref_busy,
  output logic                 ref_done,
  output logic                 ref_miss,
  output logic                 cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [BA_BITS-1:0]   ba,
  output logic [ADDR_BITS-1:0] addr
);

  localparam int WMAX = (TRP > TRFC) ? TRP : TRFC;
  localparam int WW   = $clog2(WMAX + 1);

  state_t        state, state_nxt;
  logic [WW-1:0] wcnt;
  logic          pending_nz, clr, dec;
  logic          req_d, busy_d, done_d, a10_d, a10_q;
  cmd_t          cmd_d, cmd_q;

  // Losing init_done only aborts before the bus is owned.
  assign clr = !init_done && ((state == S_IDLE) || (state == S_REQ));
  assign dec = (state == S_REF);

  ddr2_ref_timer #(.TREFI(TREFI)) u_timer (
    .ck        (ck),
    .rst_n     (rst_n),
    .init_done (init_done),
    .clr       (clr),
    .dec       (dec),
    .pending_nz(pending_nz),
    .miss      (ref_miss)
  );

  // Wait counter reloads on entry to a wait state; leaving happens when it reads 0.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRP_WAIT && state != S_TRP_WAIT)
        wcnt <= WW'(TRP - 2);
      else if (state_nxt == S_TRFC_WAIT && state != S_TRFC_WAIT)
        wcnt <= WW'(TRFC - 2);
      else if (wcnt != '0)
        wcnt <= wcnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (init_done && pending_nz) state_nxt = S_REQ;
      S_REQ:       if (!init_done)              state_nxt = S_IDLE;
                   else if (ref_grant)          state_nxt = S_PRE;
      S_PRE:                                    state_nxt = S_TRP_WAIT;
      S_TRP_WAIT:  if (wcnt == '0)              state_nxt = S_REF;
      S_REF:                                    state_nxt = S_TRFC_WAIT;
      S_TRFC_WAIT: if (wcnt == '0) begin
`ifdef DDR2_REF_POSTPONE_EN
                     state_nxt = pending_nz ? S_REF : S_DONE;
`else
                     state_nxt = S_DONE;
`endif
                   end
      S_DONE:                                   state_nxt = S_IDLE;
      default:                                  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode the next state so they can be registered without extra latency.
  always_comb begin
    req_d  = (state_nxt == S_REQ);
    busy_d = busy_state(state_nxt);
    done_d = (state_nxt == S_DONE);
    a10_d  = (state_nxt == S_PRE);
    cmd_d  = CMD_NOP;
    if (state_nxt == S_PRE)      cmd_d = CMD_PRE;
    else if (state_nxt == S_REF) cmd_d = CMD_REF;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      ref_req  <= 1'b0;
      ref_busy <= 1'b0;
      ref_done <= 1'b0;
      cmd_q    <= CMD_NOP;
      a10_q    <= 1'b0;
    end else begin
      ref_req  <= req_d;
      ref_busy <= busy_d;
      ref_done <= done_d;
      cmd_q    <= cmd_d;
      a10_q    <= a10_d;
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign ba = '0;

  always_comb begin
    addr     = '0;
    addr[10] = a10_q;
  end

endmodule

// File: tb/tb_ddr2_refresh_ctrl.sv
// Event-scoreboard bench for ddr2_refresh_ctrl (TREFI=20, TRP=3, TRFC=26).
module tb_ddr2_refresh_ctrl;
  import ddr2_refresh_ctrl_pkg::*;

  localparam int TREFI = 20;
  localparam int TRP   = 3;
  localparam int TRFC  = 26;

  localparam int EV_REQ_RISE  = 0;
  localparam int EV_REQ_FALL  = 1;
  localparam int EV_BUSY_RISE = 2;
  localparam int EV_PRE       = 3;
  localparam int EV_REF       = 4;
  localparam int EV_DONE      = 5;
  localparam int EV_BUSY_FALL = 6;
  localparam int EV_MISS      = 7;
  localparam int EV_BAD       = 8;

  typedef struct { int kind; int cyc; } ev_t;
  typedef struct { int gnt_on; int gnt_off; int exp_pre; } row_t;

  logic ck = 1'b0, rst_n = 1'b0, init_done = 1'b0, ref_grant = 1'b0;
  logic ref_req, ref_busy, ref_done, ref_miss;
  logic cs_n, ras_n, cas_n, we_n;
  logic [BA_BITS-1:0]   ba;
  logic [ADDR_BITS-1:0] addr;

  int  cyc = 0, errors = 0, checks = 0;
  ev_t expq[$];
  row_t rows[4];
  logic p_req = 1'b0, p_busy = 1'b0, p_miss = 1'b0;

  ddr2_refresh_ctrl #(.TREFI(TREFI), .TRP(TRP), .TRFC(TRFC)) dut (
    .ck(ck), .rst_n(rst_n), .init_done(init_done), .ref_req(ref_req),
    .ref_grant(ref_grant), .ref_busy(ref_busy), .ref_done(ref_done),
    .ref_miss(ref_miss), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr)
  );

  initial forever #5 ck = ~ck;
  initial forever begin @(posedge ck); cyc++; end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    expq.push_back(e);
  endtask

  task automatic seen(input int k);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL event_unexpected actual=kind%0d@%0d expected=none", k, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        errors++;
        $display("FAIL event actual=kind%0d@%0d expected=kind%0d@%0d", k, cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    logic [31:0] act;
    act = 32'({ref_req, ref_busy, ref_done, ref_miss, cs_n, ras_n, cas_n, we_n, ba, addr});
    chk(name, act, 32'h7 << (BA_BITS + ADDR_BITS));
  endtask

  task automatic drain(input string name);
    chk(name, expq.size(), 0);
    expq.delete();
  endtask

  // Output monitor: turns DUT output edges into events for the scoreboard.
  initial begin
    cmd_t cmd;
    logic [ADDR_BITS-1:0] a10;
    a10 = '0;
    a10[10] = 1'b1;
    forever begin
      @(negedge ck);
      if (!rst_n) begin
        p_req = 1'b0; p_busy = 1'b0; p_miss = 1'b0;
      end else begin
        cmd = {cs_n, ras_n, cas_n, we_n};
        if (ref_req && !p_req)  seen(EV_REQ_RISE);
        if (!ref_req && p_req)  seen(EV_REQ_FALL);
        if (ref_busy && !p_busy) seen(EV_BUSY_RISE);
        if (cmd == CMD_PRE && addr == a10 && ba == '0)      seen(EV_PRE);
        else if (cmd == CMD_REF && addr == '0 && ba == '0)  seen(EV_REF);
        else if (cmd != CMD_NOP || addr != '0 || ba != '0)  seen(EV_BAD);
        if (ref_done)            seen(EV_DONE);
        if (!ref_busy && p_busy) seen(EV_BUSY_FALL);
        if (ref_miss && !p_miss) seen(EV_MISS);
        p_req = ref_req; p_busy = ref_busy; p_miss = ref_miss;
      end
    end
  end

  task automatic do_reset();
    drain("leftover_events");
    @(negedge ck);
    init_done = 1'b0;
    ref_grant = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset_values");
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
  endtask

  task automatic run_row(input row_t r);
    int n0, p;
    @(negedge ck);
    n0 = cyc;
    p  = r.exp_pre;
    init_done = 1'b1;
    expect_ev(EV_REQ_RISE,  n0 + TREFI);
    expect_ev(EV_REQ_FALL,  n0 + p);
    expect_ev(EV_BUSY_RISE, n0 + p);
    expect_ev(EV_PRE,       n0 + p);
    expect_ev(EV_REF,       n0 + p + TRP);
    expect_ev(EV_DONE,      n0 + p + TRP + TRFC);
    expect_ev(EV_BUSY_FALL, n0 + p + TRP + TRFC);
    for (int rel = 0; rel <= p + TRP + TRFC + 4; rel++) begin
      if (rel > 0) @(negedge ck);
      if (rel == r.gnt_on)  ref_grant = 1'b1;
      if (rel == r.gnt_off) ref_grant = 1'b0;
      if (rel == p + TRP)   init_done = 1'b0;
    end
    chk("row_miss", ref_miss, 0);
  endtask

  // Grant withheld for 50 cycles: request held, bus idle, overflow handling.
  task automatic held_miss();
    int n0;
    @(negedge ck);
    n0 = cyc;
    init_done = 1'b1;
    expect_ev(EV_REQ_RISE, n0 + 20);
`ifndef DDR2_REF_POSTPONE_EN
    expect_ev(EV_MISS, n0 + 40);
`endif
    expect_ev(EV_REQ_FALL,  n0 + 71);
    expect_ev(EV_BUSY_RISE, n0 + 71);
    expect_ev(EV_PRE,       n0 + 71);
    expect_ev(EV_REF,       n0 + 74);
`ifdef DDR2_REF_POSTPONE_EN
    expect_ev(EV_REF,       n0 + 100);
    expect_ev(EV_REF,       n0 + 126);
    expect_ev(EV_DONE,      n0 + 152);
    expect_ev(EV_BUSY_FALL, n0 + 152);
`else
    expect_ev(EV_DONE,      n0 + 100);
    expect_ev(EV_BUSY_FALL, n0 + 100);
`endif
    for (int rel = 1; rel <= 156; rel++) begin
      @(negedge ck);
      if (rel >= 21 && rel <= 70)
        chk("held_req", {ref_req, ref_busy, cs_n, ras_n, cas_n, we_n}, 6'b10_0111);
      if (rel == 70) ref_grant = 1'b1;
      if (rel == 71) ref_grant = 1'b0;
      if (rel == 74) init_done = 1'b0;
    end
`ifdef DDR2_REF_POSTPONE_EN
    chk("held_miss_flag", ref_miss, 0);
`else
    chk("held_miss_flag", ref_miss, 1);
`endif
  endtask

  // Async reset mid-tRFC, restart latency, then init_done drop while requesting.
  task automatic reset_mid();
    int n0, r0;
    @(negedge ck);
    n0 = cyc;
    init_done = 1'b1;
    expect_ev(EV_REQ_RISE,  n0 + 20);
    expect_ev(EV_REQ_FALL,  n0 + 23);
    expect_ev(EV_BUSY_RISE, n0 + 23);
    expect_ev(EV_PRE,       n0 + 23);
    expect_ev(EV_REF,       n0 + 26);
    for (int rel = 1; rel <= 35; rel++) begin
      @(negedge ck);
      if (rel == 22) ref_grant = 1'b1;
      if (rel == 23) ref_grant = 1'b0;
    end
    chk("busy_in_trfc", ref_busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset_async");
    drain("reset_mid_events");
    repeat (2) @(negedge ck);
    r0 = cyc;
    rst_n = 1'b1;
    expect_ev(EV_REQ_RISE, r0 + TREFI);
    for (int rel = 1; rel <= 52; rel++) begin
      @(negedge ck);
      if (rel == 21) begin
        ref_grant = 1'b1;
        init_done = 1'b0;
        expect_ev(EV_REQ_FALL, r0 + 22);
      end
      if (rel == 25) ref_grant = 1'b0;
      if (rel == 30) begin
        init_done = 1'b1;
        expect_ev(EV_REQ_RISE, r0 + 50);
      end
    end
    chk("drop_no_busy", ref_busy, 0);
  endtask

  initial begin
    rows[0] = '{gnt_on: 22, gnt_off: 23, exp_pre: 23};
    rows[1] = '{gnt_on: 20, gnt_off: 21, exp_pre: 21};
    rows[2] = '{gnt_on: 10, gnt_off: 53, exp_pre: 21};
    rows[3] = '{gnt_on: 27, gnt_off: 28, exp_pre: 28};

    do_reset();
    repeat (30) @(negedge ck);
    chk("no_req_before_init", {ref_req, ref_busy}, 0);

    foreach (rows[i]) begin
      do_reset();
      run_row(rows[i]);
    end

    do_reset();
    held_miss();
    do_reset();
    reset_mid();
    do_reset();
    chk("miss_cleared", ref_miss, 0);
    drain("final_events");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
